dwa_selector: RTL

DWA_SELECTOR -- requirements
Module: dwa_selector

---
 rtl/dwa_selector.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/dwa_selector.sv
// ---------------------------------------------------------------------------
// dwa_selector
//   Data-weighted-averaging element selector for a unit-element DAC. Each
//   accepted quantizer level L (clamped to 0..N_ELEM) enables L consecutive
//   unit elements, starting at the rotation pointer. The pointer then
//   advances by L, so element usage is spread evenly over time and
//   mismatch errors are first-order noise shaped.
//
// Parameters
//   INPUT_WIDTH  width of the signed level input
//   N_ELEM       number of unit elements (power of two, 4..64)
//   PTR_W        derived pointer width, clog2(N_ELEM)
//
// Ports
//   clk_i        clock, rising-edge active
//   rst_i        asynchronous, active-high reset
//   level_i      signed quantized level
//   in_valid_i   level_i valid
//   in_ready_o   block can take level_i this cycle
//   sel_o        unit-element enable vector, bit i drives element i
//   out_valid_o  sel_o valid
//   out_ready_i  downstream accepts sel_o
//   ptr_o        rotation pointer (first element of the next sample)
//
// Optional feature, enabled by defining DWA_SAT_CNT_EN:
//   sat_o        registered with sel_o, 1 when the accepted level was clamped
//   sat_cnt_o    count of clamped accepts, saturating at 0xFFFF
// ---------------------------------------------------------------------------
module dwa_selector #(
    parameter int  INPUT_WIDTH = 16,
    parameter int  N_ELEM      = 16,
    localparam int PTR_W       = $clog2(N_ELEM)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic signed [INPUT_WIDTH-1:0] level_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    output logic        [N_ELEM-1:0]      sel_o,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic        [PTR_W-1:0]       ptr_o
`ifdef DWA_SAT_CNT_EN
    ,
    output logic                          sat_o,
    output logic        [15:0]            sat_cnt_o
`endif
);

    // Clamp the signed level into 0..N_ELEM. One extra bit is needed so that
    // L = N_ELEM (all elements on) is representable.
    function automatic logic [PTR_W:0] clamp_level(input logic signed [INPUT_WIDTH-1:0] lvl);
        int x;
        x = int'(lvl);
        if (x < 0)
            clamp_level = '0;
        else if (x > N_ELEM)
            clamp_level = (PTR_W+1)'(N_ELEM);
        else
            clamp_level = x[PTR_W:0];
    endfunction

    function automatic logic is_clamped(input logic signed [INPUT_WIDTH-1:0] lvl);
        int x;
        x = int'(lvl);
        is_clamped = (x < 0) || (x > N_ELEM);
    endfunction

    logic [N_ELEM-1:0] sel_q, sel_d;
    logic              vld_q, vld_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;

    logic              accept;
    logic [PTR_W:0]    lvl_clamped;
    logic [N_ELEM-1:0] rot_sel;

    // A stalled output (valid and not consumed) blocks new input; otherwise
    // the output register is free or being drained this very cycle.
    assign in_ready_o  = !vld_q || out_ready_i;
    assign accept      = in_valid_i && in_ready_o;
    assign lvl_clamped = clamp_level(level_i);

    // Element i is enabled when its distance from the pointer, taken modulo
    // N_ELEM, is below L. The modulo falls out of PTR_W-bit wrap-around, so
    // runs crossing element N_ELEM-1 continue at element 0.
    always_comb begin
        logic [PTR_W-1:0] off;
        off     = '0;
        rot_sel = '0;
        for (int i = 0; i < N_ELEM; i++) begin
            off        = PTR_W'(i) - ptr_q;
            rot_sel[i] = ({1'b0, off} < lvl_clamped);
        end
    end

    always_comb begin
        sel_d = sel_q;
        vld_d = vld_q;
        ptr_d = ptr_q;
        if (accept) begin
            sel_d = rot_sel;
            vld_d = 1'b1;
            // Dropping the top bit makes L = N_ELEM a full turn (no change).
            ptr_d = ptr_q + lvl_clamped[PTR_W-1:0];
        end else if (out_ready_i) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sel_q <= '0;
            vld_q <= 1'b0;
            ptr_q <= '0;
        end else begin
            sel_q <= sel_d;
            vld_q <= vld_d;
            ptr_q <= ptr_d;
        end
    end

    assign sel_o       = sel_q;
    assign out_valid_o = vld_q;
    assign ptr_o       = ptr_q;

`ifdef DWA_SAT_CNT_EN
    logic        sat_q, sat_d;
    logic [15:0] sat_cnt_q, sat_cnt_d;
    logic        clamp_hit;

    assign clamp_hit = is_clamped(level_i);

    always_comb begin
        sat_d     = sat_q;
        sat_cnt_d = sat_cnt_q;
        if (accept) begin
            sat_d = clamp_hit;
            if (clamp_hit && (sat_cnt_q != 16'hFFFF))
                sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sat_q     <= 1'b0;
            sat_cnt_q <= '0;
        end else begin
            sat_q     <= sat_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign sat_o     = sat_q;
    assign sat_cnt_o = sat_cnt_q;
`else
    // Keeps the clamp-flag helper referenced in builds without the counter.
    logic unused_clamp;
    assign unused_clamp = is_clamped(level_i);
`endif

endmodule
